// File: rtl/rs232tx_fifo.sv
// rs232tx_fifo: byte FIFO that drains one byte at a time into the rs232tx serializer
module rs232tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              clr_overflow,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              idle
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_ACK, S_DONE} state_t;

    state_t            state, state_nx;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [1:0]        ack_cnt;
    logic              pop, push, drop;

    assign full  = count == (ADDR_W+1)'(DEPTH);
    assign empty = count == '0;
    assign idle  = empty && state == S_IDLE;
    assign pop   = state == S_IDLE && !empty && !tx_busy;
    assign push  = wr_en && !flush && (!full || pop);
    assign drop  = wr_en && !flush && full && !pop;

    // next state: ACK gives up after 4 cycles so a lost start cannot wedge the drain
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = pop ? S_START : S_IDLE;
            S_START: state_nx = S_ACK;
            S_ACK:   state_nx = tx_busy ? S_DONE : (ack_cnt == 2'd3 ? S_IDLE : S_ACK);
            S_DONE:  state_nx = tx_busy ? S_DONE : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // state register; tx_start is registered so it mirrors S_START exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            ack_cnt  <= '0;
        end else begin
            state    <= state_nx;
            tx_start <= state_nx == S_START;
            ack_cnt  <= state == S_ACK ? ack_cnt + 2'd1 : 2'd0;
        end
    end

    // storage array, no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // pointers and occupancy; flush wins over push/pop bookkeeping but not over the popped byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        end
    end

    // popped byte is held for the serializer; sticky overflow where a new drop beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (pop) tx_data <= mem[rd_ptr];
            overflow <= drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow);
        end
    end
endmodule

// File: tb/tb_rs232tx_fifo.sv
// tb_rs232tx_fifo: scoreboard bench for rs232tx_fifo with a simple serializer model
module tb_rs232tx_fifo;
    logic       clk = 0, rst_n = 0, wr_en = 0, flush = 0, clr_overflow = 0;
    logic       force_busy = 0, model_en = 1, mb;
    logic [7:0] wr_data = 0, tx_data, exp_b;
    logic       full, empty, overflow, tx_start, idle, tx_busy;
    logic [4:0] count;
    int         mc;
    logic [7:0] q[$];
    int         n_chk = 0, n_fail = 0, n_starts = 0;

    rs232tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .clr_overflow(clr_overflow), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .idle(idle)
    );

    always #5 clk = ~clk;
    assign tx_busy = force_busy | (model_en & mb);

    // serializer model: busy for a 10-cycle frame after each start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb <= 0;
            mc <= 0;
        end else if (tx_start && model_en) begin
            mb <= 1;
            mc <= 9;
        end else if (mc != 0) mc <= mc - 1;
        else mb <= 0;
    end

    // monitor: every start pulse must carry the next expected byte
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            n_starts++;
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_start: tx_data=%0h, none expected", tx_data);
            end else begin
                exp_b = q.pop_front();
                if (tx_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL start_data: tx_data=%0h expected %0h", tx_data, exp_b);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit keep);
        wr_en = 1;
        wr_data = b;
        tick();
        wr_en = 0;
        if (keep) q.push_back(b);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q.size() != 0 || !idle || tx_busy) && n < 3000) begin
            tick();
            n++;
        end
        check(name, int'(n < 3000), 1);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!tx_busy && n < 100) begin
            tick();
            n++;
        end
        check("wait_busy", int'(tx_busy), 1);
    endtask

    initial begin
        int s0, n;
        #1;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_idle", idle, 1);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_ovf", overflow, 0);
        tick();
        rst_n = 1;
        tick();
        // reset in the middle of a frame with 3 bytes still queued
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1);
        wait_busy();
        tick();
        tick();
        check("t1_count_before", count, 3);
        rst_n = 0;
        #1;
        check("t1_count", count, 0);
        check("t1_start", tx_start, 0);
        check("t1_idle", idle, 1);
        q.delete();
        tick();
        rst_n = 1;
        repeat (30) tick();
        check("t1_idle_after", idle, 1);
        // single byte latency
        push(8'hA5, 1);
        check("t2_start_early", tx_start, 0);
        tick();
        check("t2_start", tx_start, 1);
        check("t2_data", tx_data, 8'hA5);
        check("t2_count", count, 0);
        wait_drain("t2_drain");
        repeat (10) tick();
        // burst of 16 with pointer wrap
        s0 = n_starts;
        for (int i = 0; i < 16; i++) push(8'h41 + 8'(i), 1);
        check("t3_count", count, 16 - (n_starts - s0));
        check("t3_full", full, int'(n_starts == s0));
        n = 0;
        while (count > 12 && n < 500) begin
            tick();
            n++;
        end
        check("t3_room", int'(count <= 12), 1);
        for (int i = 0; i < 4; i++) push(8'h51 + 8'(i), 1);
        check("t3_ovf", overflow, 0);
        wait_drain("t3_drain");
        // overflow, clear, set-wins, push during pop on a full FIFO
        force_busy = 1;
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 1);
        check("t4_full", full, 1);
        check("t4_count16", count, 16);
        push(8'hFF, 0);
        check("t4_ovf", overflow, 1);
        check("t4_count_drop", count, 16);
        clr_overflow = 1;
        tick();
        clr_overflow = 0;
        check("t4_clr", overflow, 0);
        clr_overflow = 1;
        push(8'hFE, 0);
        clr_overflow = 0;
        check("t4_set_wins", overflow, 1);
        clr_overflow = 1;
        tick();
        clr_overflow = 0;
        check("t4_clr2", overflow, 0);
        force_busy = 0;
        push(8'h70, 1);
        check("t4_count_pp", count, 16);
        check("t4_pop_start", tx_start, 1);
        check("t4_ovf_pp", overflow, 0);
        wait_drain("t4_drain");
        // flush with a pop in the same cycle: popped byte still goes out
        push(8'h90, 1);
        flush = 1;
        tick();
        flush = 0;
        check("t5_pop_flush_count", count, 0);
        check("t5_pop_flush_start", tx_start, 1);
        wait_drain("t5_drain_a");
        // flush with one in flight and 5 queued, plus a discarded push
        for (int i = 0; i < 6; i++) push(8'h80 + 8'(i), 1);
        wait_busy();
        check("t5_count5", count, 5);
        flush = 1;
        wr_en = 1;
        wr_data = 8'hEE;
        tick();
        flush = 0;
        wr_en = 0;
        check("t5_count", count, 0);
        check("t5_empty", empty, 1);
        check("t5_ovf", overflow, 0);
        q.delete();
        wait_drain("t5_drain_b");
        repeat (20) tick();
        // lost start: busy never rises, ACK times out after 4 cycles
        model_en = 0;
        push(8'hB1, 1);
        push(8'hB2, 1);
        check("t6_start1", tx_start, 1);
        check("t6_data1", tx_data, 8'hB1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_gap", tx_start, 0);
        end
        tick();
        check("t6_start2", tx_start, 1);
        check("t6_data2", tx_data, 8'hB2);
        wait_drain("t6_drain");
        model_en = 1;
        repeat (10) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
